// File: rtl/cbb_ones_serializer_pkg.sv
// Shared types and width helpers for the ones serializer: FSM state enum and
// the index/popcount width derivations used by the interface and the RTL.
package cbb_ones_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // An index needs at least one bit even for a single-bit vector.
    function automatic int calcIdxW(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int calcCntW(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/cbb_ones_serializer_if.sv
// Valid/ready bundle for the ones serializer: vector input side and the
// index output stream. The slave modport is the serializer itself.
interface cbb_ones_serializer_if
    import cbb_ones_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = calcIdxW(WIDTH),
    parameter int CNT_W = calcCntW(WIDTH)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;
    logic [CNT_W-1:0] out_total;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero, out_total
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero, out_total
    );

endinterface

// File: rtl/cbb_ones_serializer_count_ones.sv
// Combinational popcount cell: counts the set bits of i_data.
// o_count is wide enough to hold the all-ones case exactly.
module cbb_count_ones #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/cbb_ones_serializer.sv
// Unrolls an accepted bit vector into one beat per set bit, lowest index first,
// with back-to-back bursts when the last beat and the next vector coincide.
module cbb_ones_serializer
    import cbb_ones_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    cbb_ones_serializer_if.slave bus
);

    localparam int IDX_W = calcIdxW(WIDTH);
    localparam int CNT_W = calcCntW(WIDTH);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_pend;
    logic [CNT_W-1:0] r_total;

    logic [CNT_W-1:0] w_count;
    logic [IDX_W-1:0] w_lowIdx;
    logic [WIDTH-1:0] w_pendClr;
    logic             w_atMostOne;
    logic             w_inReady;
    logic             w_outValid;
    logic             w_accept;
    logic             w_fire;

    cbb_count_ones #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_countOnes (
        .i_data  (bus.in_data),
        .o_count (w_count)
    );

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        w_lowIdx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lowIdx = IDX_W'(i);
            end
        end
    end

    assign w_pendClr   = r_pend & (r_pend - WIDTH'(1));
    assign w_atMostOne = (w_pendClr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The last beat's handshake reopens the input in the same cycle, so a
    // waiting vector is taken with no idle cycle between bursts.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) begin
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_outValid = 1'b1;
                if (bus.out_ready && w_atMostOne) begin
                    w_inReady   = 1'b1;
                    w_nextState = bus.in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign w_accept = bus.in_valid && w_inReady;
    assign w_fire   = w_outValid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_total <= '0;
        end else if (w_accept) begin
            r_pend  <= bus.in_data;
            r_total <= w_count;
        end else if (w_fire) begin
            r_pend  <= w_pendClr;
        end
    end

    // Outputs are forced to zero outside a burst so idle reads are clean.
    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_idx   = w_outValid ? w_lowIdx : '0;
    assign bus.out_last  = w_outValid && w_atMostOne;
    assign bus.out_zero  = w_outValid && (r_total == '0);
    assign bus.out_total = w_outValid ? r_total : '0;

endmodule

// File: tb/tb_cbb_ones_serializer.sv
// Directed bench for cbb_ones_serializer: an 8-bit instance for the main
// scenarios and a 1-bit instance for the degenerate width.
module tb_cbb_ones_serializer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   fires;

    cbb_ones_serializer_if #(.WIDTH(8)) bus ();
    cbb_ones_serializer_if #(.WIDTH(1)) bus1 ();

    cbb_ones_serializer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cbb_ones_serializer #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
        @(negedge clk);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        #1;
    endtask

    task automatic applyStimulusNarrow(input logic valid, input logic data, input logic ready);
        @(negedge clk);
        bus1.in_valid  = valid;
        bus1.in_data   = data;
        bus1.out_ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input bit narrow, input logic expValid,
                               input int expIdx, input logic expLast, input logic expZero,
                               input int expTotal, input logic expInReady);
        logic        obsValid, obsLast, obsZero, obsInReady;
        logic [31:0] obsIdx, obsTotal, eIdx, eTotal;
        eIdx   = 32'(expIdx);
        eTotal = 32'(expTotal);
        if (narrow) begin
            obsValid   = bus1.out_valid;
            obsIdx     = 32'(bus1.out_idx);
            obsLast    = bus1.out_last;
            obsZero    = bus1.out_zero;
            obsTotal   = 32'(bus1.out_total);
            obsInReady = bus1.in_ready;
        end else begin
            obsValid   = bus.out_valid;
            obsIdx     = 32'(bus.out_idx);
            obsLast    = bus.out_last;
            obsZero    = bus.out_zero;
            obsTotal   = 32'(bus.out_total);
            obsInReady = bus.in_ready;
        end
        checks++;
        assert (obsValid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s.valid observed=%b expected=%b", tag, obsValid, expValid);
        end
        checks++;
        assert (obsIdx === eIdx) else begin
            errors++;
            $error("[TB] FAIL %s.idx observed=%0d expected=%0d", tag, obsIdx, eIdx);
        end
        checks++;
        assert (obsLast === expLast) else begin
            errors++;
            $error("[TB] FAIL %s.last observed=%b expected=%b", tag, obsLast, expLast);
        end
        checks++;
        assert (obsZero === expZero) else begin
            errors++;
            $error("[TB] FAIL %s.zero observed=%b expected=%b", tag, obsZero, expZero);
        end
        checks++;
        assert (obsTotal === eTotal) else begin
            errors++;
            $error("[TB] FAIL %s.total observed=%0d expected=%0d", tag, obsTotal, eTotal);
        end
        checks++;
        assert (obsInReady === expInReady) else begin
            errors++;
            $error("[TB] FAIL %s.in_ready observed=%b expected=%b", tag, obsInReady, expInReady);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fires  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = 1'b0;  bus1.out_ready = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("reset_w1", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // 8'hA4: indices 2, 5, 7, first beat the cycle after accept
        applyStimulus(1'b1, 8'hA4, 1'b1);
        checkOutput("a4_accept", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("a4_beat0", 1'b0, 1'b1, 2, 1'b0, 1'b0, 3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("a4_beat1", 1'b0, 1'b1, 5, 1'b0, 1'b0, 3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("a4_beat2", 1'b0, 1'b1, 7, 1'b1, 1'b0, 3, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("a4_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Zero vector: a single beat flagged as empty
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("zero_beat", 1'b0, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("zero_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // 8'hFF with out_ready alternating: each beat stalls once, then fires
        applyStimulus(1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("ff_stall%0d", k), 1'b0, 1'b1, k, k == 7, 1'b0, 8, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("ff_fire%0d", k), 1'b0, 1'b1, k, k == 7, 1'b0, 8, k == 7);
            if (bus.out_valid && bus.out_ready) fires++;
        end
        checks++;
        assert (fires === 8) else begin
            errors++;
            $error("[TB] FAIL ff_handshakes observed=%0d expected=8", fires);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ff_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // 8'h81 then 8'h02 offered continuously: no gap between bursts
        applyStimulus(1'b1, 8'h81, 1'b1);
        checkOutput("b2b_accept", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        checkOutput("b2b_idx0", 1'b0, 1'b1, 0, 1'b0, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b1);
        checkOutput("b2b_idx7", 1'b0, 1'b1, 7, 1'b1, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("b2b_idx1", 1'b0, 1'b1, 1, 1'b1, 1'b0, 1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("b2b_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Asynchronous reset mid-burst of 8'h0F, then 8'h10
        applyStimulus(1'b1, 8'h0F, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rst_idx0", 1'b0, 1'b1, 0, 1'b0, 1'b0, 4, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rst_idx1", 1'b0, 1'b1, 1, 1'b0, 1'b0, 4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_release", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 8'h10, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rst_next", 1'b0, 1'b1, 4, 1'b1, 1'b0, 1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rst_next_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

        // WIDTH=1 instance
        applyStimulusNarrow(1'b1, 1'b1, 1'b1);
        applyStimulusNarrow(1'b0, 1'b0, 1'b1);
        checkOutput("w1_one", 1'b1, 1'b1, 0, 1'b1, 1'b0, 1, 1'b1);
        applyStimulusNarrow(1'b1, 1'b0, 1'b1);
        checkOutput("w1_idle", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulusNarrow(1'b0, 1'b0, 1'b1);
        checkOutput("w1_zero", 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
